// File: rtl/pipe_hazard_pkg.sv
// Shared widths, latency constants and the counter-width helper for the ID-stage hazard scoreboard.
// Pure declarations; no timing or handshake of its own.
package pipe_hazard_pkg;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_MAX_LAT    = 8;
  localparam int DEF_CNT_W      = clog2(DEF_MAX_LAT + 1);
  localparam int DEF_PERF_W     = 32;

  localparam logic [DEF_CNT_W-1:0] LAT_ALU  = DEF_CNT_W'(1);
  localparam logic [DEF_CNT_W-1:0] LAT_LOAD = DEF_CNT_W'(2);
  localparam logic [DEF_CNT_W-1:0] LAT_MUL  = DEF_CNT_W'(4);
  localparam logic [DEF_CNT_W-1:0] LAT_DIV  = DEF_CNT_W'(8);

endpackage

// File: rtl/pipe_hazard_scoreboard_if.sv
// ID-stage issue request toward the scoreboard and the stall/flush/status answer back.
// All answers are combinational in the same cycle; the ID stage holds its request while stalled.
interface pipe_hazard_scoreboard_if
  import pipe_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int NUM_REGS   = 2 ** REG_ADDR_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int PERF_W     = DEF_PERF_W
);

  logic                  issue_valid_d;
  logic [REG_ADDR_W-1:0] rs_d;
  logic [REG_ADDR_W-1:0] rt_d;
  logic                  rs_used_d;
  logic                  rt_used_d;
  logic                  branch_d;
  logic                  branch_taken_d;
  logic                  wr_en_d;
  logic [REG_ADDR_W-1:0] wr_reg_d;
  logic [CNT_W-1:0]      wr_lat_d;
  logic                  ext_use_d;
  logic                  ext_busy_i;

  logic                  StallF;
  logic                  StallD;
  logic                  FlushE;
  logic                  FlushD;
  logic [NUM_REGS-1:0]   busy_o;
  logic [PERF_W-1:0]     stall_cnt_o;

  modport master (
    output issue_valid_d, rs_d, rt_d, rs_used_d, rt_used_d, branch_d, branch_taken_d,
    output wr_en_d, wr_reg_d, wr_lat_d, ext_use_d, ext_busy_i,
    input  StallF, StallD, FlushE, FlushD, busy_o, stall_cnt_o
  );

  modport slave (
    input  issue_valid_d, rs_d, rt_d, rs_used_d, rt_used_d, branch_d, branch_taken_d,
    input  wr_en_d, wr_reg_d, wr_lat_d, ext_use_d, ext_busy_i,
    output StallF, StallD, FlushE, FlushD, busy_o, stall_cnt_o
  );

endinterface

// File: rtl/hazard_reg_timer.sv
// One register's result-pending countdown: load clamps to MAX_LAT, otherwise counts down to 0.
// Updates on the clock edge only; busy is a plain decode of the current count.
module hazard_reg_timer #(
  parameter int CNT_W   = 4,
  parameter int MAX_LAT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             busy_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // A fresh load overrides the running countdown: the newest producer owns the register.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (load_val_i > CNT_W'(MAX_LAT)) ? CNT_W'(MAX_LAT) : load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// ID-stage hazard unit: per-register countdown scoreboard driving stall/flush with zero-cycle latency.
// A hazard holds IF/ID and bubbles EX; the stalled instruction is expected to be re-presented.
module pipe_hazard_scoreboard
  import pipe_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int NUM_REGS   = 2 ** REG_ADDR_W,
  parameter int MAX_LAT    = DEF_MAX_LAT,
  parameter int CNT_W      = clog2(MAX_LAT + 1),
  parameter int PERF_W     = DEF_PERF_W
) (
  input logic                    clk,
  input logic                    rst_n,
  pipe_hazard_scoreboard_if.slave hif
);

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            busy;
  logic [CNT_W-1:0]               cnt_a, cnt_b, raw_thr;
  logic                           raw_a, raw_b, struct_hz, hz, fire, load_en;
  logic [PERF_W-1:0]              stall_cnt_d, stall_cnt_q;

  assign cnt[0]  = '0;
  assign busy[0] = 1'b0;

  // Branches compare in ID so they need the value one cycle earlier than an EX consumer.
  always_comb begin
    cnt_a     = cnt[hif.rs_d];
    cnt_b     = cnt[hif.rt_d];
    raw_thr   = hif.branch_d ? CNT_W'(0) : CNT_W'(1);
    raw_a     = hif.rs_used_d & (hif.rs_d != '0) & (cnt_a > raw_thr);
    raw_b     = hif.rt_used_d & (hif.rt_d != '0) & (cnt_b > raw_thr);
    struct_hz = hif.ext_use_d & hif.ext_busy_i;
    hz        = hif.issue_valid_d & (raw_a | raw_b | struct_hz);
    fire      = hif.issue_valid_d & ~hz;
    load_en   = fire & hif.wr_en_d & (hif.wr_lat_d != '0);
  end

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    hazard_reg_timer #(
      .CNT_W   (CNT_W),
      .MAX_LAT (MAX_LAT)
    ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load_en & (hif.wr_reg_d == REG_ADDR_W'(r))),
      .load_val_i (hif.wr_lat_d),
      .cnt_o      (cnt[r]),
      .busy_o     (busy[r])
    );
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hz && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  // FlushD is qualified by issue_valid_d so an idle ID slot never leaks X into IF/ID.
  assign hif.StallF      = hz;
  assign hif.StallD      = hz;
  assign hif.FlushE      = hz;
  assign hif.FlushD      = hif.issue_valid_d & hif.branch_taken_d & ~hz;
  assign hif.busy_o      = busy;
  assign hif.stall_cnt_o = stall_cnt_q;

endmodule
